ps2_rx: RTL and testbench



---
 rtl/ps2_rx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver in the clk domain. Synchronises and de-glitches
//   the raw PS/2 clock/data lines, frames start + 8 data (LSB first) + odd
//   parity + stop, and strobes each validated scan-code byte for one cycle.
// Latency: a clean raw ps2_clk fall is seen ~2 + FILTER_LEN cycles later;
//   data_valid / frame_err are registered, one cycle after the stop-bit fall.
// Backpressure: none; the consumer must take data_out on the data_valid pulse
//   (data_out holds until the next good frame).
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   ps2_clk        - raw PS/2 clock line      ps2_data - raw PS/2 data line
//   data_out[7:0]  - last valid scan code     data_valid - 1-cycle new-byte strobe
//   frame_err      - 1-cycle parity/stop/timeout error strobe
//   busy           - high while a frame is in progress
// Build option: define PS2_RX_PARITY_EN to reject frames with bad odd parity;
//   otherwise the parity bit slot is consumed but not checked.

module ps2_rx #(
  parameter int FILTER_LEN = 4,       // 1..15 samples to accept a clock level
  parameter int TIMEOUT    = 100000   // clk cycles allowed between falls
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------
  // Synchronisers, reset to the idle bus level
  // ---------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_s;
  logic       dat_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // ---------------------------------------------------------------------
  // Clock de-glitch filter: clk_f follows clk_s only after clk_s has
  // disagreed with it for FILTER_LEN consecutive cycles.
  // ---------------------------------------------------------------------
  logic       clk_f_q, clk_f_d;
  logic [3:0] run_q, run_d;
  logic       fall;

  always_comb begin
    clk_f_d = clk_f_q;
    run_d   = 4'd0;
    if (clk_s != clk_f_q) begin
      if (run_q == 4'(FILTER_LEN - 1)) begin
        clk_f_d = clk_s;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f_q <= 1'b1;
      run_q   <= 4'd0;
    end else begin
      clk_f_q <= clk_f_d;
      run_q   <= run_d;
    end
  end

  // The fall is flagged in the cycle the filter decides to switch, so the
  // data line is sampled alongside it with no extra register stage.
  assign fall = clk_f_q & ~clk_f_d;

  // ---------------------------------------------------------------------
  // Framing FSM and inter-edge timeout
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          par_ok;

`ifdef PS2_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  // Odd parity: data bits plus parity bit hold an odd number of ones.
  assign par_ok = ^{shift_q, par_q};
`else
  // Parity slot still advances the FSM; its value is not used.
  assign par_ok = 1'b1;
`endif

  assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef PS2_RX_PARITY_EN
    par_d   = par_q;
`endif

    if (fall || state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    // A fall coinciding with the timeout wins over the timeout.
    if (fall) begin
      case (state_q)
        IDLE: begin
          // A high data line at a fall is a spurious edge, not a start bit.
          if (!dat_s) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end
        DATA: begin
          shift_d = {dat_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_EN
          par_d   = dat_s;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s && par_ok) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

  localparam int FLEN = 4;
  localparam int TMO  = 600;
  localparam int HALF = 40;   // ps2_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;   // expected data_out when the strobe is seen
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_last = 8'h00;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         done     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what a frame should yield, from the frame rules only.
  task automatic expect_frame(input logic [7:0] d, input bit p, input bit s);
    bit   odd_ok;
    bit   accept;
    exp_t e;
    odd_ok = (($countones(d) + int'(p)) % 2) == 1;
`ifdef PS2_RX_PARITY_EN
    accept = s && odd_ok;
`else
    accept = s;
    if (odd_ok) accept = s;
`endif
    if (accept) model_last = d;
    e.err = !accept;
    e.dat = model_last;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.err = 1'b1;
    e.dat = model_last;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a result.
  always @(negedge clk) begin
    if (!rst && !done) begin
      if (data_valid && frame_err) begin
        check("valid_and_err_exclusive", 1, 0);
      end else if (data_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {data_valid, frame_err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind_err", frame_err, e.err);
          check("data_out", data_out, e.dat);
          check("busy_at_strobe", busy, 0);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of start,d[0..7],parity,stop.
  task automatic send_frame(input logic [7:0] d, input bit p, input bit s, input int nbits);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    if (nbits == 11) expect_frame(d, p, s);
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i]);
      if (i == 0 || i == 9) check("busy_in_frame", busy, 1);
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      wait_clks(1);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    wait_clks(4);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit         p, s;

    wait_clks(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clks(5);

    // Good frame 0x1C (3 ones, parity 0).
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    drain(200);

    // Back-to-back 0xF0 then 0x1C.
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    drain(200);

    // 0x1C with wrong parity: build-dependent outcome via the model.
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    drain(200);

    // Bad stop bit, then a good repeat.
    send_frame(8'h5A, 1'b1, 1'b0, 11);
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    drain(200);

    // Partial frame then silence: timeout error, then recovery.
    expect_err();
    send_frame(8'h0F, 1'b0, 1'b1, 4);
    wait_clks(TMO + 10);
    drain(50);
    send_frame(8'h66, 1'b1, 1'b1, 11);
    drain(200);

    // Short low glitch while idle: must not start a frame.
    ps2_clk = 1'b0;
    wait_clks(2);
    ps2_clk = 1'b1;
    wait_clks(20);
    check("glitch_busy", busy, 0);

    // Reset mid-frame after the 5th data bit.
    send_frame(8'hA3, 1'b0, 1'b1, 6);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    wait_clks(2);
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_err", frame_err, 0);
    model_last = 8'h00;
    rst = 1'b0;
    wait_clks(5);
    send_frame(8'h75, 1'b1, 1'b1, 11);
    drain(200);

    // Randomized frames with occasional bad parity / stop.
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      p = ~(^d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, 11);
      if ($urandom_range(0, 1) == 0) drain(200);
    end
    drain(200);

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
